// File: rtl/extra_counter.sv
// Extra cycle counter: shifts the T1 pulse through T2..T5, plus the PHI1/PHI2 clock phases.
// Define EXCNT_NOUT_EN to add the active-low outputs n_T2..n_T5.
module extra_counter (
   input  logic PHI0,
   input  logic TRES2,
   input  logic n_ready,
   input  logic T1,
   output logic PHI1,
   output logic PHI2,
   output logic T2,
   output logic T3,
   output logic T4,
   output logic T5
`ifdef EXCNT_NOUT_EN
   ,
   output logic n_T2,
   output logic n_T3,
   output logic n_T4,
   output logic n_T5
`endif
);

   // s_q[0] is T2 ... s_q[3] is T5; a pulse moves one stage per ready cycle.
   logic [3:0] s_q;
   logic [3:0] s_d;

   assign PHI2 = PHI0;
   assign PHI1 = ~PHI0;

   always_comb begin
      s_d = s_q;
      if (!n_ready) begin
         s_d = {s_q[2:0], T1};
      end
   end

   always_ff @(posedge PHI0) begin
      if (TRES2) begin
         s_q <= 4'b0000;
      end else begin
         s_q <= s_d;
      end
   end

   assign T2 = s_q[0];
   assign T3 = s_q[1];
   assign T4 = s_q[2];
   assign T5 = s_q[3];

`ifdef EXCNT_NOUT_EN
   assign n_T2 = ~s_q[0];
   assign n_T3 = ~s_q[1];
   assign n_T4 = ~s_q[2];
   assign n_T5 = ~s_q[3];
`endif

endmodule

// File: tb/tb_extra_counter.sv
// Bench for extra_counter: directed test-plan steps, then random steps against a T1-history model.
// Build with EXCNT_NOUT_EN defined to also cover n_T2..n_T5.
module tb_extra_counter;

   logic PHI0 = 1'b0;
   logic TRES2 = 1'b0;
   logic n_ready = 1'b0;
   logic T1 = 1'b0;
   logic PHI1, PHI2, T2, T3, T4, T5;
`ifdef EXCNT_NOUT_EN
   logic n_T2, n_T3, n_T4, n_T5;
`endif

   int checks = 0;
   int errors = 0;

   // Model: T(n) is the T1 value seen (n-2) ready edges ago; reset fills the history with 0.
   logic [0:0] exp_q[$];
   int known_edges = 0;

   extra_counter dut (
      .PHI0    (PHI0),
      .TRES2   (TRES2),
      .n_ready (n_ready),
      .T1      (T1),
      .PHI1    (PHI1),
      .PHI2    (PHI2),
      .T2      (T2),
      .T3      (T3),
      .T4      (T4),
      .T5      (T5)
`ifdef EXCNT_NOUT_EN
      ,
      .n_T2    (n_T2),
      .n_T3    (n_T3),
      .n_T4    (n_T4),
      .n_T5    (n_T5)
`endif
   );

   always #5 PHI0 = ~PHI0;

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %b expected %b", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] flags();
      return {T2, T3, T4, T5};
   endfunction

   function automatic logic [3:0] model_flags();
      return {exp_q[0], exp_q[1], exp_q[2], exp_q[3]};
   endfunction

   task automatic check_clocks(input string tag);
      check({tag, "_phi"}, {2'b00, PHI1, PHI2}, {2'b00, ~PHI0, PHI0});
   endtask

   // One clock edge: drive at the falling edge, update the model at the rising edge, sample 1 unit later.
   task automatic step(input logic tres, input logic nrdy, input logic t1, input string tag);
      @(negedge PHI0);
      #1;
      check_clocks({tag, "_low"});
      TRES2   = tres;
      n_ready = nrdy;
      T1      = t1;
      @(posedge PHI0);
      if (tres) begin
         exp_q = '{1'b0, 1'b0, 1'b0, 1'b0};
         known_edges = 4;
      end else if (!nrdy) begin
         exp_q.push_front(t1);
         void'(exp_q.pop_back());
         known_edges++;
      end
      #1;
      check_clocks({tag, "_high"});
      if (known_edges >= 4) begin
         check(tag, flags(), model_flags());
`ifdef EXCNT_NOUT_EN
         check({tag, "_n"}, {n_T2, n_T3, n_T4, n_T5}, ~model_flags());
`endif
      end
   endtask

   initial begin
      exp_q = '{1'b0, 1'b0, 1'b0, 1'b0};

      // 1. Flush from undefined power-up, then a single pulse walks through.
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, "flush");
      check("flush_const", flags(), 4'b0000);
      step(1'b0, 1'b0, 1'b1, "pulse_t2");
      check("pulse_t2_const", flags(), 4'b1000);
      step(1'b0, 1'b0, 1'b0, "pulse_t3");
      check("pulse_t3_const", flags(), 4'b0100);
      step(1'b0, 1'b0, 1'b0, "pulse_t4");
      step(1'b0, 1'b0, 1'b0, "pulse_t5");
      check("pulse_t5_const", flags(), 4'b0001);
      step(1'b0, 1'b0, 1'b0, "pulse_end");
      check("pulse_end_const", flags(), 4'b0000);

      // 2. Stall holds T3; a T1 arriving while not ready is lost.
      step(1'b0, 1'b0, 1'b1, "stall_a");
      step(1'b0, 1'b0, 1'b0, "stall_b");
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, (i == 1), "stall_hold");
      check("stall_hold_const", flags(), 4'b0100);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, "stall_resume");
      check("stall_resume_const", flags(), 4'b0000);

      // 3. Reset mid-sequence.
      step(1'b0, 1'b0, 1'b1, "rst_a");
      step(1'b0, 1'b0, 1'b0, "rst_b");
      step(1'b1, 1'b0, 1'b0, "rst_first");
      check("rst_first_const", flags(), 4'b0000);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, "rst_hold");
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, "rst_after");
      check("rst_after_const", flags(), 4'b0000);

      // 4. Priority: reset beats not-ready and T1; not-ready ignores T1.
      step(1'b0, 1'b0, 1'b1, "prio_load");
      step(1'b1, 1'b1, 1'b1, "prio_rst");
      check("prio_rst_const", flags(), 4'b0000);
      step(1'b0, 1'b0, 1'b1, "prio_load2");
      step(1'b0, 1'b1, 1'b1, "prio_hold");
      check("prio_hold_const", flags(), 4'b1000);
      step(1'b1, 1'b0, 1'b0, "prio_clr");

      // 5. Back-to-back T1 gives several set bits; held T1 fills with ones.
      step(1'b0, 1'b0, 1'b1, "multi_1");
      step(1'b0, 1'b0, 1'b1, "multi_2");
      check("multi_2_const", flags(), 4'b1100);
      step(1'b0, 1'b0, 1'b0, "multi_3");
      check("multi_3_const", flags(), 4'b0110);
      step(1'b0, 1'b0, 1'b0, "multi_4");
      check("multi_4_const", flags(), 4'b0011);
      step(1'b0, 1'b0, 1'b0, "multi_5");
      step(1'b0, 1'b0, 1'b0, "multi_6");
      check("multi_6_const", flags(), 4'b0000);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, "fill");
      check("fill_const", flags(), 4'b1111);

      // Random traffic: sparse resets, frequent stalls, random T1.
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) == 0),
              1'($urandom_range(0, 1)), "random");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      errors++;
      $display("FAIL timeout observed running expected finished");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "timeout");
   end

endmodule
